bayer_line_buffer: RTL and testbench
====================================

// Module: bayer_line_buffer
// PURPOSE
//  Upstream stage of the debayer. Takes the raw 2-pixel/clock Bayer stream from the sensor
//  deserialiser and stores one active line in a single-port-style line RAM. Presents each
//  current pixel pair together with the same-column pair from the line above.
//  Also generates the odd-line flag and the line-start pulse the debayer consumes.
//  All outputs have a fixed 1-cycle latency.
// PARAMETERS
//  MAX_PAIRS   2112  max pixel pairs per active line (4224 px / 2)
//  ADDR_W      12    line RAM address width; must satisfy 2**ADDR_W >= MAX_PAIRS
// PORTS
//  clock                  in   1   pixel clock, all logic rising-edge
//  reset_n                in   1   asynchronous active-low reset
//  input_hsync            in   1   raw hsync
//  input_vsync            in   1   raw vsync, active high
//  input_den              in   1   active-pixel enable
//  input_data             in   20  {pixel_n+1[9:0], pixel_n[9:0]}, raw Bayer
//  output_hsync           out  1   input_hsync delayed 1 clk
//  output_vsync           out  1   input_vsync delayed 1 clk
//  output_den             out  1   input_den delayed 1 clk
//  output_line_start      out  1   1-clk pulse with first output_den of each line
//  output_odd_line        out  1   line parity: 0 on line 0 of each frame, then alternates
//  output_data            out  20  input_data delayed 1 clk
//  output_prev_line_data  out  20  same-column pair from the previous line; 0 on line 0
//  output_line_pairs      out  ADDR_W+1  pair count of the last completed line
//  output_overflow        out  1   sticky: a line exceeded MAX_PAIRS; cleared at vsync rise
// BEHAVIOUR
//  Reset:
//   - All outputs = 0.
//   - wr_addr = 0, parity = 0, first_line = 1.
//   - The RAM contents are not reset.
//  Edge detection uses registered copies of vsync and den: vs_rise, den_fall.
//  Per cycle with input_den = 1:
//   - If wr_addr < MAX_PAIRS:
//     - Read RAM[wr_addr] (read-before-write).
//     - Write input_data to RAM[wr_addr].
//     - wr_addr++.
//   - Otherwise: no write, wr_addr holds, and output_overflow <= 1.
//   - Overflow pairs are still passed through on output_data.
//     Their output_prev_line_data = 0.
//  Read data is registered (1 clk) and lands with the delayed output_data. Forced to 0 when:
//   - first_line = 1, or
//   - the address is at or beyond the previous line's length.
//  Line end (den_fall):
//   - output_line_pairs <= wr_addr.
//   - wr_addr <= 0.
//   - parity toggles.
//   - first_line <= 0.
//  Frame start (vs_rise):
//   - wr_addr <= 0, parity <= 0, first_line <= 1.
//   - output_overflow <= 0.
//   - The previous-line length is treated as 0.
//  Simultaneous events:
//   - vs_rise together with den_fall: the vs_rise actions win (parity = 0, not toggled).
//     output_line_pairs is still updated.
//   - vs_rise together with input_den = 1: the pair is written at address 0 as pixel 0 of line 0.
//   - output_overflow set and clear in the same cycle: the clear wins.
//  output_line_start:
//   - Asserted on the delayed cycle of the first input_den after reset, den_fall, or vs_rise.
//   - Exactly one pulse per line.
//  output_odd_line:
//   - Equals the parity of the line the delayed pair belongs to.
//   - Held between lines.
//  hsync is only delayed; line boundaries are derived from den alone.
//  Reset mid-line: all state returns to reset values. The next den starts line 0 with no
//  prev-line data.
// TESTING
//  - Reset, then frame of 3 lines x 4 pairs, data = {line, idx}
//    -> line 0 prev = 0; line 1 prev = line 0 pairs column by column; odd = 0, 1, 0;
//       3 line_start pulses; output_line_pairs = 4.
//  - Latency: single den pulse with data 0xABCDE
//    -> output_data = 0xABCDE and output_den = 1 exactly 1 clk later.
//  - Line of MAX_PAIRS + 3 pairs -> overflow = 1; last 3 pairs have prev = 0; line_pairs = 2112;
//    next vsync rise clears overflow.
//  - Short line after long: line 0 = 6 pairs, line 1 = 2 pairs, line 2 = 4 pairs
//    -> line 2 pairs 2..3 have prev = 0.
//  - vsync rise on the same cycle as den_fall -> odd_line of the next line = 0;
//    next line prev = 0.
//  - reset_n low mid-line 1, then release and send 2 lines -> first line odd = 0, prev = 0.

Source files
------------

// File: rtl/bayer_line_buffer_if.sv
// Stream bundle between the sensor deserialiser, the line buffer and the debayer.
// The slave side belongs to the line buffer; the master side belongs to whatever drives it.
interface bayer_line_buffer_if #(
    parameter int ADDR_W = 12
);
    logic              input_hsync;
    logic              input_vsync;
    logic              input_den;
    logic [19:0]       input_data;
    logic              output_hsync;
    logic              output_vsync;
    logic              output_den;
    logic              output_line_start;
    logic              output_odd_line;
    logic [19:0]       output_data;
    logic [19:0]       output_prev_line_data;
    logic [ADDR_W:0]   output_line_pairs;
    logic              output_overflow;

    modport master (
        output input_hsync, input_vsync, input_den, input_data,
        input  output_hsync, output_vsync, output_den, output_line_start, output_odd_line,
        input  output_data, output_prev_line_data, output_line_pairs, output_overflow
    );

    modport slave (
        input  input_hsync, input_vsync, input_den, input_data,
        output output_hsync, output_vsync, output_den, output_line_start, output_odd_line,
        output output_data, output_prev_line_data, output_line_pairs, output_overflow
    );
endinterface

// File: rtl/bayer_line_buffer.sv
// One-line Bayer buffer: delays the 2-pixel stream by one clock and pairs each pixel pair
// with the same-column pair of the previous line, plus line parity and line-start flags.
module bayer_line_buffer #(
    parameter int MAX_PAIRS = 2112,
    parameter int ADDR_W    = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    bayer_line_buffer_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_PAIRS);

    logic [19:0]      r_ram [0:MAX_PAIRS-1];
    logic [19:0]      r_ram_q;
    logic             r_hs_d;
    logic             r_vs_d;
    logic             r_den_d;
    logic [19:0]      r_data;
    logic [CNT_W-1:0] r_wr_addr;
    logic [CNT_W-1:0] r_line_pairs;
    logic             r_parity;
    logic             r_first_line;
    logic             r_pending;
    logic             r_line_start;
    logic             r_odd;
    logic             r_overflow;
    logic             r_prev_valid;

    logic             w_vs_rise;
    logic             w_den_fall;
    logic [CNT_W-1:0] w_addr;
    logic             w_in_range;
    logic             w_wr_en;
    logic             w_first;
    logic             w_parity;
    logic             w_prev_ok;

    // A vsync rise restarts the frame in the same cycle, so a coincident pair lands at address 0.
    assign w_vs_rise  = bus.input_vsync & ~r_vs_d;
    assign w_den_fall = ~bus.input_den & r_den_d;
    assign w_addr     = w_vs_rise ? '0 : r_wr_addr;
    assign w_in_range = (w_addr < LIMIT);
    assign w_wr_en    = bus.input_den & w_in_range;
    assign w_first    = w_vs_rise | r_first_line;
    assign w_parity   = w_vs_rise ? 1'b0 : r_parity;
    assign w_prev_ok  = w_wr_en & ~w_first & (w_addr < r_line_pairs);

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_ram_q <= r_ram[w_addr[ADDR_W-1:0]];
            r_ram[w_addr[ADDR_W-1:0]] <= bus.input_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d       <= 1'b0;
            r_vs_d       <= 1'b0;
            r_den_d      <= 1'b0;
            r_data       <= '0;
            r_wr_addr    <= '0;
            r_line_pairs <= '0;
            r_parity     <= 1'b0;
            r_first_line <= 1'b1;
            r_pending    <= 1'b1;
            r_line_start <= 1'b0;
            r_odd        <= 1'b0;
            r_overflow   <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_hs_d       <= bus.input_hsync;
            r_vs_d       <= bus.input_vsync;
            r_den_d      <= bus.input_den;
            r_data       <= bus.input_data;
            r_prev_valid <= w_prev_ok;
            r_line_start <= bus.input_den & (r_pending | w_vs_rise);

            if (w_den_fall)
                r_wr_addr <= '0;
            else if (w_wr_en)
                r_wr_addr <= w_addr + CNT_W'(1);
            else
                r_wr_addr <= w_addr;

            if (w_den_fall)
                r_line_pairs <= r_wr_addr;

            if (w_vs_rise)
                r_parity <= 1'b0;
            else if (w_den_fall)
                r_parity <= ~r_parity;

            if (w_vs_rise)
                r_first_line <= 1'b1;
            else if (w_den_fall)
                r_first_line <= 1'b0;

            if (bus.input_den)
                r_pending <= 1'b0;
            else if (w_vs_rise | w_den_fall)
                r_pending <= 1'b1;

            if (bus.input_den)
                r_odd <= w_parity;

            // Clear has priority over a same-cycle overflow.
            if (w_vs_rise)
                r_overflow <= 1'b0;
            else if (bus.input_den & ~w_in_range)
                r_overflow <= 1'b1;
        end
    end

    assign bus.output_hsync          = r_hs_d;
    assign bus.output_vsync          = r_vs_d;
    assign bus.output_den            = r_den_d;
    assign bus.output_data           = r_data;
    assign bus.output_line_start     = r_line_start;
    assign bus.output_odd_line       = r_odd;
    assign bus.output_overflow       = r_overflow;
    assign bus.output_line_pairs     = r_line_pairs;
    assign bus.output_prev_line_data = r_prev_valid ? r_ram_q : '0;
endmodule

// File: tb/tb_bayer_line_buffer.sv
// Directed bench for bayer_line_buffer: drives frames of short, long and truncated lines
// and checks every delayed output against hand-derived values.
module tb_bayer_line_buffer;
    localparam int MAX_PAIRS = 2112;
    localparam int ADDR_W    = 12;

    logic clock;
    logic reset_n;
    int   compared;
    int   mismatched;

    bayer_line_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    bayer_line_buffer #(
        .MAX_PAIRS(MAX_PAIRS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
    task automatic applyStimulus(input logic vs, input logic den, input logic [19:0] data);
        bus.input_vsync = vs;
        bus.input_den   = den;
        bus.input_hsync = ~den;
        bus.input_data  = data;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sendLine(input logic [19:0] base, input int n, input logic [19:0] prevBase,
                            input int prevLen, input logic odd);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, base + 20'(i));
            checkOutput("data",   32'(bus.output_data), 32'(base + 20'(i)));
            checkOutput("den",    32'(bus.output_den), 32'd1);
            checkOutput("prev",   32'(bus.output_prev_line_data),
                        (i < prevLen) ? 32'(prevBase + 20'(i)) : 32'd0);
            checkOutput("odd",    32'(bus.output_odd_line), 32'(odd));
            checkOutput("lstart", 32'(bus.output_line_start), (i == 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic endLine(input int expPairs);
        applyStimulus(1'b0, 1'b0, 20'h0);
        checkOutput("gap_den",    32'(bus.output_den), 32'd0);
        checkOutput("gap_lstart", 32'(bus.output_line_start), 32'd0);
        checkOutput("line_pairs", 32'(bus.output_line_pairs), 32'(expPairs));
        applyStimulus(1'b0, 1'b0, 20'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        bus.input_hsync = 1'b0;
        bus.input_vsync = 1'b0;
        bus.input_den   = 1'b0;
        bus.input_data  = 20'h0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_data",  32'(bus.output_data), 32'd0);
        checkOutput("rst_den",   32'(bus.output_den), 32'd0);
        checkOutput("rst_prev",  32'(bus.output_prev_line_data), 32'd0);
        checkOutput("rst_pairs", 32'(bus.output_line_pairs), 32'd0);
        checkOutput("rst_ovf",   32'(bus.output_overflow), 32'd0);
        checkOutput("rst_odd",   32'(bus.output_odd_line), 32'd0);
        checkOutput("rst_ls",    32'(bus.output_line_start), 32'd0);
        reset_n = 1'b1;

        // Frame of 3 lines x 4 pairs.
        applyStimulus(1'b1, 1'b0, 20'h0);
        checkOutput("vs_out", 32'(bus.output_vsync), 32'd1);
        sendLine(20'h00100, 4, 20'h0, 0, 1'b0);
        endLine(4);
        sendLine(20'h01100, 4, 20'h00100, 4, 1'b1);
        endLine(4);
        sendLine(20'h02100, 4, 20'h01100, 4, 1'b0);
        endLine(4);

        // Single-pair latency check; continues the frame as line 3.
        checkOutput("lat_pre_den", 32'(bus.output_den), 32'd0);
        applyStimulus(1'b0, 1'b1, 20'hABCDE);
        checkOutput("lat_data", 32'(bus.output_data), 32'hABCDE);
        checkOutput("lat_den",  32'(bus.output_den), 32'd1);
        checkOutput("lat_hs",   32'(bus.output_hsync), 32'd0);
        checkOutput("lat_odd",  32'(bus.output_odd_line), 32'd1);
        checkOutput("lat_prev", 32'(bus.output_prev_line_data), 32'h02100);
        applyStimulus(1'b0, 1'b0, 20'h0);
        checkOutput("lat_post_den", 32'(bus.output_den), 32'd0);
        checkOutput("lat_post_hs",  32'(bus.output_hsync), 32'd1);
        checkOutput("lat_pairs",    32'(bus.output_line_pairs), 32'd1);
        applyStimulus(1'b0, 1'b0, 20'h0);

        // Full-length line, then a line 3 pairs too long.
        applyStimulus(1'b1, 1'b0, 20'h0);
        sendLine(20'h10000, MAX_PAIRS, 20'h0, 0, 1'b0);
        endLine(MAX_PAIRS);
        checkOutput("ovf_full", 32'(bus.output_overflow), 32'd0);
        sendLine(20'h20000, MAX_PAIRS + 3, 20'h10000, MAX_PAIRS, 1'b1);
        endLine(MAX_PAIRS);
        checkOutput("ovf_set", 32'(bus.output_overflow), 32'd1);
        applyStimulus(1'b1, 1'b0, 20'h0);
        checkOutput("ovf_clr", 32'(bus.output_overflow), 32'd0);

        // Short line after long: stale RAM beyond the 2-pair line must not leak.
        sendLine(20'h30000, 6, 20'h0, 0, 1'b0);
        endLine(6);
        sendLine(20'h31000, 2, 20'h30000, 6, 1'b1);
        endLine(2);
        sendLine(20'h32000, 4, 20'h31000, 2, 1'b0);
        endLine(4);

        // vsync rise in the same cycle as den fall.
        applyStimulus(1'b1, 1'b0, 20'h0);
        sendLine(20'h40000, 3, 20'h0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 20'h0);
        checkOutput("vsdf_pairs", 32'(bus.output_line_pairs), 32'd3);
        applyStimulus(1'b0, 1'b0, 20'h0);
        sendLine(20'h41000, 2, 20'h0, 0, 1'b0);
        endLine(2);

        // Reset in the middle of line 1.
        applyStimulus(1'b1, 1'b0, 20'h0);
        sendLine(20'h50000, 3, 20'h0, 0, 1'b0);
        endLine(3);
        sendLine(20'h51000, 2, 20'h50000, 3, 1'b1);
        reset_n         = 1'b0;
        bus.input_den   = 1'b0;
        bus.input_hsync = 1'b1;
        bus.input_data  = 20'h0;
        #1;
        checkOutput("mrst_den",   32'(bus.output_den), 32'd0);
        checkOutput("mrst_odd",   32'(bus.output_odd_line), 32'd0);
        checkOutput("mrst_pairs", 32'(bus.output_line_pairs), 32'd0);
        checkOutput("mrst_data",  32'(bus.output_data), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        sendLine(20'h60000, 3, 20'h0, 0, 1'b0);
        endLine(3);
        sendLine(20'h61000, 3, 20'h60000, 3, 1'b1);
        endLine(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
